pcihellocore_leds: RTL
======================

PCIHELLOCORE_LEDS -- requirements
Module: pcihellocore_leds

Interface
REQ-001 SHALL have parameter WIDTH, 8, output port width (1..32).
REQ-002 SHALL have parameter RESET_VALUE, 0, DATA register reset value (WIDTH bits).
REQ-003 SHALL have parameter PULSE_LEN, 16, pulse duration in clk cycles (1..65535).
REQ-004 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  3  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  write strobe, active-low.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  registered read data.
REQ-011 SHALL have port out_port  output  WIDTH  registered LED/output pins.

Function
REQ-012 SHALL accept a write on a cycle with chipselect=1 and write_n=0; zero wait states, no waitrequest.
REQ-013 SHALL implement map: 0 DATA R/W; 1 STATUS R, write clears err; 2 PULSE W; 4 OUTSET W; 5 OUTCLEAR W; 3,6,7 unmapped.
REQ-014 SHALL on DATA write load data_reg <= writedata[WIDTH-1:0]; upper bits ignored.
REQ-015 SHALL on OUTSET write do data_reg <= data_reg | writedata[WIDTH-1:0]; on OUTCLEAR write data_reg <= data_reg & ~writedata[WIDTH-1:0].
REQ-016 SHALL drive out_port <= data_reg_next ^ pulse_mask_next, registered, so a write at edge k is visible on out_port after edge k.
REQ-017 SHALL run pulse FSM: IDLE, ACTIVE.
REQ-018 SHALL in IDLE, on PULSE write with nonzero writedata[WIDTH-1:0], load pulse_mask, load counter=PULSE_LEN-1, go ACTIVE.
REQ-019 SHALL in IDLE ignore PULSE write of zero mask (no state change, no err).
REQ-020 SHALL in ACTIVE decrement counter each cycle; at counter=0 clear pulse_mask and go IDLE, so the mask is XORed onto out_port for exactly PULSE_LEN cycles.
REQ-021 SHALL in ACTIVE ignore any PULSE write and set sticky STATUS.err (bit1); pulse timing unaffected.
REQ-022 SHALL let DATA/OUTSET/OUTCLEAR writes during ACTIVE update data_reg immediately; out_port = new data_reg ^ mask.
REQ-023 SHALL clear STATUS.err on any STATUS write; if the same cycle sets err (impossible, single port), set wins.
REQ-024 SHALL return STATUS = {30'b0, err, busy}, busy=1 iff state ACTIVE.
REQ-025 SHALL register readdata every clk: readdata <= selected register zero-extended to 32 bits when chipselect=1, else 0; read latency 1 cycle.
REQ-026 SHALL return 0 for PULSE, OUTSET, OUTCLEAR, unmapped addresses; DATA reads return data_reg (not out_port).
REQ-027 SHALL have reads free of side effects.

Reset
REQ-028 SHALL on reset_n=0 asynchronously set data_reg=RESET_VALUE, out_port=RESET_VALUE, pulse_mask=0, counter=0, state=IDLE, err=0, readdata=0.
REQ-029 SHALL abort any active pulse on reset mid-operation; first cycle after deassertion is IDLE.

Structure
REQ-030 SHALL place register offsets (ADDR_DATA..ADDR_OUTCLEAR) and STATUS bit indices in shared package pcihellocore_pio_pkg, also used by the keys input port.
REQ-031 SHALL implement FSM+counter as sub-module pcihellocore_pulse_timer (start, mask in; busy, mask out).

Verification
REQ-032 SHALL test reset: reset_n low mid-pulse -> out_port=RESET_VALUE, readdata=0, STATUS read=0x0 after release.
REQ-033 SHALL test DATA write 0x1A5 at addr0 -> out_port=0xA5 next cycle; read addr0 -> readdata=0x000000A5 one cycle later.
REQ-034 SHALL test DATA=0xF0, OUTSET 0x03, OUTCLEAR 0x30 -> out_port 0xF3 then 0xC3.
REQ-035 SHALL test DATA=0x00, PULSE 0x81, PULSE_LEN=16 -> out_port=0x81 exactly 16 cycles then 0x00; STATUS=0x1 during, 0x0 after.
REQ-036 SHALL test PULSE 0x01 then PULSE 0x02 while busy -> second ignored, STATUS=0x3; STATUS write -> STATUS=0x1 or 0x0.
REQ-037 SHALL test DATA write 0x0F during pulse mask 0x81 -> out_port=0x8E until pulse ends, then 0x0F.

Source files
------------

// File: rtl/pcihellocore_pio_pkg.sv
// Shared register map and status layout for the pcihellocore PIO blocks
// (LED output port and keys input port).
package pcihellocore_pio_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PULSE    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_ERR_BIT  = 1;

    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_e;

    // Assemble the STATUS word from its flag bits.
    function automatic logic [DATA_W-1:0] status_word(input logic err, input logic busy);
        logic [DATA_W-1:0] w;
        w                  = '0;
        w[STATUS_ERR_BIT]  = err;
        w[STATUS_BUSY_BIT] = busy;
        return w;
    endfunction

endpackage

// File: rtl/pcihellocore_pulse_timer.sv
// One-shot pulse timer: holds a mask for exactly PULSE_LEN cycles after a
// start with a nonzero mask; starts while busy are ignored.
module pcihellocore_pulse_timer
    import pcihellocore_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PULSE_LEN = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] mask_nxt_c
);

    pulse_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mask_q;

    assign busy_o = (state_q == PULSE_ACTIVE);

    // Next mask value, exported so the output register can merge it same-cycle.
    always_comb begin
        mask_nxt_c = mask_q;
        if (state_q == PULSE_IDLE) begin
            if (start_i && (mask_i != '0)) begin
                mask_nxt_c = mask_i;
            end
        end else if (cnt_q == '0) begin
            mask_nxt_c = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PULSE_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            mask_q <= mask_nxt_c;
            case (state_q)
                PULSE_IDLE: begin
                    if (start_i && (mask_i != '0)) begin
                        state_q <= PULSE_ACTIVE;
                        cnt_q   <= CNT_W'(PULSE_LEN - 1);
                    end
                end
                PULSE_ACTIVE: begin
                    if (cnt_q == '0) begin
                        state_q <= PULSE_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= PULSE_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pcihellocore_leds.sv
// Avalon-MM LED output port with set/clear/pulse registers and a sticky
// error flag for pulse requests that arrive while a pulse is running.
module pcihellocore_leds
    import pcihellocore_pio_pkg::*;
#(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned     PULSE_LEN   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             pulse_wr;
    logic             busy;
    logic [WIDTH-1:0] mask_nxt;
    logic [DATA_W-1:0] rdata_d;

    assign wr_en        = chipselect && !write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // Register write decode; err set takes priority over clear.
    always_comb begin
        data_d   = data_q;
        err_d    = err_q;
        pulse_wr = 1'b0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d   = wdata;
                ADDR_STATUS:   err_d    = 1'b0;
                ADDR_PULSE:    pulse_wr = 1'b1;
                ADDR_OUTSET:   data_d   = data_q | wdata;
                ADDR_OUTCLEAR: data_d   = data_q & ~wdata;
                default:       ;
            endcase
        end
        if (pulse_wr && busy) begin
            err_d = 1'b1;
        end
    end

    // Read mux; reads have no side effects.
    always_comb begin
        rdata_d = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:   rdata_d = DATA_W'(data_q);
                ADDR_STATUS: rdata_d = status_word(err_q, busy);
                default:     rdata_d = '0;
            endcase
        end
    end

    pcihellocore_pulse_timer #(
        .WIDTH     (WIDTH),
        .PULSE_LEN (PULSE_LEN)
    ) u_pulse_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (pulse_wr),
        .mask_i     (wdata),
        .busy_o     (busy),
        .mask_nxt_c (mask_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            out_port <= RESET_VALUE;
            err_q    <= 1'b0;
            readdata <= '0;
        end else begin
            data_q   <= data_d;
            out_port <= data_d ^ mask_nxt;
            err_q    <= err_d;
            readdata <= rdata_d;
        end
    end

endmodule
